// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - opcode/handshake inputs and datapath control strobes
// master = control FSM, slave = datapath side.
interface mips_multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic       reg_dst;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
           reg_dst, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write,
           reg_dst, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS main control FSM
// Optional addi support (EXEC_I/I_DONE) built when MIPS_CTRL_ADDI_EN is defined.
module mips_multicycle_control (
  input  logic                              clk,
  input  logic                              reset,
  mips_multicycle_control_if.master         bus
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef MIPS_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_DONE   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
`ifdef MIPS_CTRL_ADDI_EN
    ,
    S_EXEC_I   = 4'd11,
    S_I_DONE   = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   ctl_q;

  // Moore decode; evaluated on the next state so the registered copy lines up with state_q.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_DONE:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`ifdef MIPS_CTRL_ADDI_EN
      S_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_I_DONE:   c.reg_write = 1'b1;
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_R:         state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_EXEC_I;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.op == OP_LW)      state_d = S_MEM_RD;
        else if (bus.op == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD: state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R: state_d = S_R_DONE;
`ifdef MIPS_CTRL_ADDI_EN
      S_EXEC_I: state_d = S_I_DONE;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d);
    end
  end

  // The only Mealy terms: fetch strobes wait on mem_ready, illegal_op flags a DECODE that falls back to FETCH.
  assign bus.ir_write      = (state_q == S_FETCH) && bus.mem_ready;
  assign bus.pc_write      = ctl_q.pc_write | ((state_q == S_FETCH) && bus.mem_ready);
  assign bus.illegal_op    = (state_q == S_DECODE) && (state_d == S_FETCH);
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.i_or_d        = ctl_q.i_or_d;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.pc_source     = ctl_q.pc_source;
  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.state         = state_q;

endmodule
